// File: rtl/riscv_instr_prefetch_queue_if.sv
// Instruction-bus bundle between the prefetcher (master) and instruction memory (slave).
// req/addr travel to memory; gnt/rvalid/rdata/err_pmp travel back.
interface riscv_instr_prefetch_queue_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_pmp_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i,
        input  instr_err_pmp_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i,
        output instr_err_pmp_i
    );
endinterface

// File: rtl/riscv_instr_prefetch_queue.sv
// Sequential instruction prefetcher with a small {addr,rdata} FIFO feeding the IF stage.
// Optional PREFETCH_BYPASS_EN: forward bus data to IF in the same cycle when the queue is empty.
module riscv_instr_prefetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        fetch_failed_o,
    output logic        busy_o,
    riscv_instr_prefetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED} state_t;

    state_t          state_reg;
    logic [31:0]     fetch_addr_reg;
    logic            failed_reg;
    logic [CW-1:0]   count_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [31:0]     addr_mem [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic [31:0]     branch_addr;
    logic [31:0]     seq_addr;
    logic            inflight;
    logic            resp;
    logic            resp_keep;
    logic            fifo_valid;
    logic            bypass;
    logic            bypass_take;
    logic            push;
    logic            pop;
    logic            failed_base;
    logic            room;
    logic            issue;
    logic [CW-1:0]   count_base;
    logic [CW:0]     slots;
    logic            addr_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign addr_unused = ^addr_i[1:0];
    assign branch_addr = {addr_i[31:2], 2'b00};
    // fetch_addr_reg holds the address of the outstanding fetch until its data returns.
    assign seq_addr    = fetch_addr_reg + 32'd4;
    assign inflight    = (state_reg == WAIT_RVALID) || (state_reg == WAIT_ABORTED);
    assign resp        = bus.instr_rvalid_i && inflight;
    assign resp_keep   = resp && (state_reg == WAIT_RVALID) && !branch_i;
    assign fifo_valid  = (count_reg != '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass      = resp_keep && !fifo_valid;
    assign bypass_take = bypass && ready_i;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign push        = resp_keep && !bypass_take;
    assign pop         = fifo_valid && ready_i && !branch_i;

    // A branch empties the queue and clears the fault in the same cycle, so the
    // room check already sees the post-flush occupancy.
    assign count_base  = branch_i ? '0 : count_reg;
    assign failed_base = branch_i ? 1'b0 : failed_reg;
    assign slots       = {1'b0, count_base} + {{CW{1'b0}}, push};
    assign room        = slots < (CW + 1)'(DEPTH);
    assign issue       = ((state_reg == IDLE) || resp) && req_i && !failed_base && room;

    assign bus.instr_req_o  = (state_reg == WAIT_GNT) || issue;
    assign bus.instr_addr_o = branch_i                    ? branch_addr :
                              (state_reg == WAIT_RVALID)  ? seq_addr    : fetch_addr_reg;

    assign valid_o        = fifo_valid || bypass;
    assign rdata_o        = bypass ? bus.instr_rdata_i : (fifo_valid ? data_mem[rd_ptr_reg] : '0);
    assign addr_o         = bypass ? fetch_addr_reg    : (fifo_valid ? addr_mem[rd_ptr_reg] : '0);
    assign fetch_failed_o = failed_reg;
    assign busy_o         = (state_reg != IDLE) || inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            fetch_addr_reg <= '0;
            failed_reg     <= 1'b0;
        end else begin
            if (branch_i) begin
                fetch_addr_reg <= branch_addr;
            end else if (resp && (state_reg == WAIT_RVALID)) begin
                fetch_addr_reg <= seq_addr;
            end

            if (bus.instr_req_o && bus.instr_err_pmp_i) begin
                state_reg  <= IDLE;
                failed_reg <= 1'b1;
            end else begin
                if (branch_i) begin
                    failed_reg <= 1'b0;
                end
                if (bus.instr_req_o) begin
                    state_reg <= bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end else if (resp) begin
                    state_reg <= IDLE;
                end else if (branch_i && (state_reg == WAIT_RVALID)) begin
                    state_reg <= WAIT_ABORTED;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (branch_i) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= fetch_addr_reg;
            data_mem[wr_ptr_reg] <= bus.instr_rdata_i;
        end
    end
endmodule

// File: tb/tb_riscv_instr_prefetch_queue.sv
// Directed bench for riscv_instr_prefetch_queue; memory returns rdata = addr ^ 32'hDEAD_0000.
// Define PREFETCH_BYPASS_EN to also exercise the same-cycle bypass path.
module tb_riscv_instr_prefetch_queue;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        branch = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] addr = '0;
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] head_addr;
    logic        fetch_failed;
    logic        busy;

    logic        gnt_en = 1'b1;
    logic        pmp_en = 1'b0;
    logic [31:0] pmp_addr = '0;
    int          rv_delay = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    int          gnt_count = 0;

    int checks = 0;
    int failures = 0;

    riscv_instr_prefetch_queue_if bus();

    riscv_instr_prefetch_queue #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .branch_i       (branch),
        .addr_i         (addr),
        .ready_i        (ready),
        .valid_o        (valid),
        .rdata_o        (rdata),
        .addr_o         (head_addr),
        .fetch_failed_o (fetch_failed),
        .busy_o         (busy),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Memory model: grant on request, data returns rv_delay+1 cycles after the grant.
    assign bus.instr_err_pmp_i = pmp_en && bus.instr_req_o && (bus.instr_addr_o == pmp_addr);
    assign bus.instr_gnt_i     = gnt_en && bus.instr_req_o && !bus.instr_err_pmp_i;
    assign bus.instr_rvalid_i  = pend && (cnt == 0);
    assign bus.instr_rdata_i   = pend_addr ^ KEY;

    always @(posedge clk) begin
        if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
        if (bus.instr_gnt_i) begin
            pend      <= 1'b1;
            pend_addr <= bus.instr_addr_o;
            cnt       <= rv_delay;
            gnt_count <= gnt_count + 1;
            $display("bus grant addr=%h", bus.instr_addr_o);
        end
    end

    task automatic pop_word(output logic ok, output logic [31:0] a, output logic [31:0] d);
        ok = 1'b0;
        a  = '0;
        d  = '0;
        for (int i = 0; i < 30; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                a  = head_addr;
                d  = rdata;
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                #1;
                $display("pop addr=%h data=%h", a, d);
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic quiesce;
        int n;
        req = 1'b0; ready = 1'b0; branch = 1'b0;
        pmp_en = 1'b0; gnt_en = 1'b1; rv_delay = 0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL quiesce_timeout busy=%b required 0", busy);
        end
        branch = 1'b1; addr = '0;
        @(negedge clk);
        branch = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({valid, bus.instr_req_o, fetch_failed, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b required 0000", {valid, bus.instr_req_o, fetch_failed, busy});
        end
        checks++;
        if ({bus.instr_addr_o, head_addr, rdata} !== 96'h0) begin
            failures++;
            $display("FAIL reset_values got=%h required 0", {bus.instr_addr_o, head_addr, rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({valid, bus.instr_req_o, busy} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle got=%b required 000", {valid, bus.instr_req_o, busy});
        end
    endtask

    task automatic test_sequential;
        logic ok; logic [31:0] a, d;
        req = 1'b1; branch = 1'b1; addr = 32'h80;
        #1;
        checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h80) begin
            failures++;
            $display("FAIL seq_issue req=%b addr=%h required 1/00000080", bus.instr_req_o, bus.instr_addr_o);
        end
        @(negedge clk);
        branch = 1'b0;
        #1;
        checks++;
`ifdef PREFETCH_BYPASS_EN
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL seq_latency valid=%b required 1", valid);
        end
`else
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL seq_latency valid=%b required 0", valid);
        end
`endif
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h80 || d !== 32'hDEAD0080) begin
            failures++;
            $display("FAIL seq_word0 ok=%b addr=%h data=%h required 00000080/dead0080", ok, a, d);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h84 || d !== 32'hDEAD0084) begin
            failures++;
            $display("FAIL seq_word1 ok=%b addr=%h data=%h required 00000084/dead0084", ok, a, d);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h88 || d !== 32'hDEAD0088) begin
            failures++;
            $display("FAIL seq_word2 ok=%b addr=%h data=%h required 00000088/dead0088", ok, a, d);
        end
        quiesce();
    endtask

    task automatic test_fill;
        int g0, reqs;
        logic ok; logic [31:0] a, d;
        ready = 1'b0; g0 = gnt_count;
        req = 1'b1; branch = 1'b1; addr = 32'h1000;
        @(negedge clk);
        branch = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.instr_req_o === 1'b1) reqs++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (gnt_count - g0 !== 2) begin
            failures++;
            $display("FAIL fill_grants got=%0d required 2", gnt_count - g0);
        end
        checks++;
        if (reqs !== 0) begin
            failures++;
            $display("FAIL fill_req_quiet got=%0d requests required 0", reqs);
        end
        checks++;
        if (valid !== 1'b1 || head_addr !== 32'h1000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_head valid=%b addr=%h busy=%b required 1/00001000/0", valid, head_addr, busy);
        end
        pop_word(ok, a, d);
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h1004 || d !== 32'hDEAD1004) begin
            failures++;
            $display("FAIL fill_word1 ok=%b addr=%h data=%h required 00001004/dead1004", ok, a, d);
        end
        quiesce();
    endtask

    task automatic test_abort;
        logic ok; logic [31:0] a, d;
        ready = 1'b0; rv_delay = 0;
        req = 1'b1; branch = 1'b1; addr = 32'h400;
        @(negedge clk);
        branch = 1'b0; rv_delay = 3;
        @(negedge clk);
        #1;
        checks++;
        if (valid !== 1'b1 || head_addr !== 32'h400) begin
            failures++;
            $display("FAIL abort_prefill valid=%b addr=%h required 1/00000400", valid, head_addr);
        end
        branch = 1'b1; addr = 32'h200; rv_delay = 0;
        @(negedge clk);
        branch = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_flush valid=%b busy=%b required 0/1", valid, busy);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h200 || d !== 32'hDEAD0200) begin
            failures++;
            $display("FAIL abort_target ok=%b addr=%h data=%h required 00000200/dead0200", ok, a, d);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h204 || d !== 32'hDEAD0204) begin
            failures++;
            $display("FAIL abort_next ok=%b addr=%h data=%h required 00000204/dead0204", ok, a, d);
        end
        quiesce();
    endtask

    task automatic test_pmp;
        int reqs;
        logic ok; logic [31:0] a, d;
        ready = 1'b0; pmp_en = 1'b1; pmp_addr = 32'h100;
        req = 1'b1; branch = 1'b1; addr = 32'hF8;
        @(negedge clk);
        branch = 1'b0;
        #1;
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'hF8 || d !== 32'hDEAD00F8) begin
            failures++;
            $display("FAIL pmp_word0 ok=%b addr=%h data=%h required 000000f8/dead00f8", ok, a, d);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'hFC || d !== 32'hDEAD00FC) begin
            failures++;
            $display("FAIL pmp_drain ok=%b addr=%h data=%h required 000000fc/dead00fc", ok, a, d);
        end
        checks++;
        if (fetch_failed !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pmp_flag failed=%b busy=%b required 1/0", fetch_failed, busy);
        end
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.instr_req_o === 1'b1) reqs++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (reqs !== 0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL pmp_stopped requests=%0d valid=%b required 0/0", reqs, valid);
        end
        branch = 1'b1; addr = 32'h300;
        @(negedge clk);
        branch = 1'b0;
        #1;
        checks++;
        if (fetch_failed !== 1'b0) begin
            failures++;
            $display("FAIL pmp_clear failed=%b required 0", fetch_failed);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h300 || d !== 32'hDEAD0300) begin
            failures++;
            $display("FAIL pmp_restart ok=%b addr=%h data=%h required 00000300/dead0300", ok, a, d);
        end
        quiesce();
    endtask

    task automatic test_wrap;
        logic ok; logic [31:0] a, d;
        ready = 1'b0;
        req = 1'b1; branch = 1'b1; addr = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (bus.instr_addr_o !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_first addr=%h required fffffffc", bus.instr_addr_o);
        end
        @(negedge clk);
        branch = 1'b0;
        #1;
        checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next req=%b addr=%h required 1/00000000", bus.instr_req_o, bus.instr_addr_o);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'hFFFF_FFFC || d !== 32'h2152_FFFC) begin
            failures++;
            $display("FAIL wrap_word0 ok=%b addr=%h data=%h required fffffffc/2152fffc", ok, a, d);
        end
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h0 || d !== 32'hDEAD_0000) begin
            failures++;
            $display("FAIL wrap_word1 ok=%b addr=%h data=%h required 00000000/dead0000", ok, a, d);
        end
        quiesce();
    endtask

    task automatic test_wait_gnt;
        logic ok; logic [31:0] a, d;
        ready = 1'b0; gnt_en = 1'b0;
        req = 1'b1; branch = 1'b1; addr = 32'h700;
        @(negedge clk);
        branch = 1'b0;
        #1;
        checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h700 || busy !== 1'b1) begin
            failures++;
            $display("FAIL gnt_hold req=%b addr=%h busy=%b required 1/00000700/1", bus.instr_req_o, bus.instr_addr_o, busy);
        end
        branch = 1'b1; addr = 32'h743;
        #1;
        checks++;
        if (bus.instr_addr_o !== 32'h740) begin
            failures++;
            $display("FAIL gnt_redirect addr=%h required 00000740", bus.instr_addr_o);
        end
        @(negedge clk);
        branch = 1'b0; gnt_en = 1'b1;
        #1;
        pop_word(ok, a, d);
        checks++;
        if (!ok || a !== 32'h740 || d !== 32'hDEAD0740) begin
            failures++;
            $display("FAIL gnt_word ok=%b addr=%h data=%h required 00000740/dead0740", ok, a, d);
        end
        quiesce();
    endtask

    task automatic test_reset_mid;
        rv_delay = 2;
        req = 1'b1; branch = 1'b1; addr = 32'h500;
        @(negedge clk);
        branch = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy got=%b required 1", busy);
        end
        req = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async busy=%b valid=%b required 0/0", busy, valid);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({valid, busy, bus.instr_req_o} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_late_rvalid got=%b required 000", {valid, busy, bus.instr_req_o});
        end
        quiesce();
    endtask

`ifdef PREFETCH_BYPASS_EN
    task automatic test_bypass;
        ready = 1'b1;
        req = 1'b1; branch = 1'b1; addr = 32'h600;
        @(negedge clk);
        branch = 1'b0; req = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b1 || head_addr !== 32'h600 || rdata !== 32'hDEAD0600) begin
            failures++;
            $display("FAIL bypass_same_cycle valid=%b addr=%h data=%h required 1/00000600/dead0600", valid, head_addr, rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_not_queued valid=%b required 0", valid);
        end
        quiesce();
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_abort();
        test_pmp();
        test_wrap();
        test_wait_gnt();
        test_reset_mid();
`ifdef PREFETCH_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
